// File: rtl/timer_controller_pkg.sv
// Shared types and constants for the egg-timer control block.
package timer_controller_pkg;

    localparam int unsigned BcdWidth = 4;

    typedef logic [BcdWidth-1:0] bcd_t;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StLoad  = 3'd1,
        StRun   = 3'd2,
        StPause = 3'd3,
        StAlarm = 3'd4
    } state_e;

    function automatic bcd_t bcd_digit(input int unsigned value);
        return bcd_t'(value % 10);
    endfunction

endpackage

// File: rtl/bcd_setpoint_field.sv
// Two-digit BCD setpoint register: +1 per inc pulse, ones carry into tens, wraps to 00 at Max.
module bcd_setpoint_field
    import timer_controller_pkg::*;
#(
    parameter int unsigned Max = 59
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                inc_i,
    output logic [BcdWidth-1:0] ones_o,
    output logic [BcdWidth-1:0] tens_o
);

    localparam bcd_t MaxOnes = bcd_digit(Max);
    localparam bcd_t MaxTens = bcd_digit(Max / 10);

    bcd_t ones_q, ones_d;
    bcd_t tens_q, tens_d;
    logic at_max;

    assign at_max = (ones_q == MaxOnes) && (tens_q == MaxTens);

    always_comb begin
        ones_d = ones_q;
        tens_d = tens_q;
        if (inc_i) begin
            if (at_max) begin
                ones_d = '0;
                tens_d = '0;
            end else if (ones_q == bcd_t'(9)) begin
                ones_d = '0;
                tens_d = tens_q + bcd_t'(1);
            end else begin
                ones_d = ones_q + bcd_t'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ones_q <= '0;
            tens_q <= '0;
        end else begin
            ones_q <= ones_d;
            tens_q <= tens_d;
        end
    end

    assign ones_o = ones_q;
    assign tens_o = tens_q;

endmodule

// File: rtl/timer_controller.sv
// Egg-timer control FSM: setpoint entry, counter load/enable, and timed blinking alarm.
module timer_controller
    import timer_controller_pkg::*;
#(
    parameter int unsigned AlarmSecs = 10,
    parameter int unsigned SecMax    = 59,
    parameter int unsigned MinMax    = 99
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                tick_1s_i,
    input  logic                btn_start_i,
    input  logic                btn_stop_i,
    input  logic                btn_inc_sec_i,
    input  logic                btn_inc_min_i,
    input  logic                all_zero_i,
    output logic [BcdWidth-1:0] set_sec_ones_o,
    output logic [BcdWidth-1:0] set_sec_tens_o,
    output logic [BcdWidth-1:0] set_min_ones_o,
    output logic [BcdWidth-1:0] set_min_tens_o,
    output logic                load_o,
    output logic                count_en_o,
    output logic                alarm_o,
    output logic                blink_o,
    output logic [2:0]          state_dbg_o
);

    localparam logic [3:0] AlarmLast = 4'(AlarmSecs);

    state_e     state_q, state_d;
    logic [3:0] alarm_cnt_q, alarm_cnt_d;
    logic       blink_q, blink_d;
    logic       in_idle;
    logic       setpoint_zero;

    assign in_idle = (state_q == StIdle);

    bcd_setpoint_field #(
        .Max (SecMax)
    ) u_sec_field (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .inc_i   (btn_inc_sec_i & in_idle),
        .ones_o  (set_sec_ones_o),
        .tens_o  (set_sec_tens_o)
    );

    bcd_setpoint_field #(
        .Max (MinMax)
    ) u_min_field (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .inc_i   (btn_inc_min_i & in_idle),
        .ones_o  (set_min_ones_o),
        .tens_o  (set_min_tens_o)
    );

    assign setpoint_zero = (set_sec_ones_o == '0) && (set_sec_tens_o == '0) &&
                           (set_min_ones_o == '0) && (set_min_tens_o == '0);

    always_comb begin
        state_d     = state_q;
        alarm_cnt_d = alarm_cnt_q;
        blink_d     = blink_q;
        unique case (state_q)
            StIdle: begin
                if (btn_start_i && !setpoint_zero) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                state_d = StRun;
            end
            StRun: begin
                if (all_zero_i) begin
                    state_d = StAlarm;
                end else if (btn_stop_i) begin
                    state_d = StPause;
                end
            end
            StPause: begin
                if (btn_stop_i) begin
                    state_d = StLoad;
                end else if (btn_start_i) begin
                    state_d = StRun;
                end
            end
            StAlarm: begin
                if (tick_1s_i) begin
                    alarm_cnt_d = alarm_cnt_q + 4'd1;
                    blink_d     = ~blink_q;
                end
                if (btn_start_i || btn_stop_i ||
                    (tick_1s_i && (alarm_cnt_q + 4'd1 == AlarmLast))) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        // Counter and blink are only meaningful inside ALARM; clearing here covers entry and exit.
        if (state_d != StAlarm) begin
            alarm_cnt_d = '0;
            blink_d     = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            alarm_cnt_q <= '0;
            blink_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            alarm_cnt_q <= alarm_cnt_d;
            blink_q     <= blink_d;
        end
    end

    assign load_o      = (state_q == StLoad);
    assign count_en_o  = (state_q == StRun) & tick_1s_i & ~all_zero_i;
    assign alarm_o     = (state_q == StAlarm);
    assign blink_o     = blink_q;
    assign state_dbg_o = state_q;

endmodule
